// File: rtl/fa_nibble_seq_sched.sv
// Round-robin scheduler sharing one 4-bit adder between two requesters;
// wide sums are rippled through it one nibble per cycle, LSB nibble first.
module fa_nibble_seq_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [4*NIBBLES-1:0]   req0_a,
  input  logic [4*NIBBLES-1:0]   req0_b,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [4*NIBBLES-1:0]   req1_a,
  input  logic [4*NIBBLES-1:0]   req1_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*NIBBLES-1:0]   rsp_sum,
  output logic                   rsp_c_out,
  output logic                   rsp_id,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [4:0] add_nibble(input logic [3:0] a, input logic [3:0] b,
                                            input logic c);
    add_nibble = {1'b0, a} + {1'b0, b} + {4'b0000, c};
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            id_q, id_d;
  logic            last_grant_q, last_grant_d;
  logic [W-1:0]    rsp_sum_q, rsp_sum_d;
  logic            rsp_c_out_q, rsp_c_out_d;
  logic            rsp_id_q, rsp_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            busy_q, busy_d;

  logic            grant_s;
  logic            accept_s;
  logic [CW+1:0]   shamt_s;
  logic [W-1:0]    a_shift_s;
  logic [W-1:0]    b_shift_s;
  logic [4:0]      nib_res_s;
  logic [W-1:0]    work_upd_s;

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    req0_ready = (state_q == IDLE) & ~grant_s & req0_valid;
    req1_ready = (state_q == IDLE) &  grant_s & req1_valid;
    accept_s   = req0_ready | req1_ready;
  end

  // Shared nibble adder datapath for the current counter position.
  always_comb begin
    shamt_s    = {cnt_q, 2'b00};
    a_shift_s  = a_q >> shamt_s;
    b_shift_s  = b_q >> shamt_s;
    nib_res_s  = add_nibble(a_shift_s[3:0], b_shift_s[3:0], carry_q);
    work_upd_s = (work_q & ~(W'(4'hF) << shamt_s)) | (W'(nib_res_s[3:0]) << shamt_s);
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_c_out_d  = rsp_c_out_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d          = grant_s ? req1_a : req0_a;
          b_d          = grant_s ? req1_b : req0_b;
          id_d         = grant_s;
          last_grant_d = grant_s;
          work_d       = {W{1'b0}};
          carry_d      = 1'b0;
          cnt_d        = {CW{1'b0}};
          state_d      = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d  = work_upd_s;
        carry_d = nib_res_s[4];
        if (cnt_q == LAST_CNT) begin
          // Result registers only change here, so they stay stable otherwise.
          cnt_d       = {CW{1'b0}};
          rsp_sum_d   = work_upd_s;
          rsp_c_out_d = nib_res_s[4];
          rsp_id_d    = id_q;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= {W{1'b0}};
      b_q          <= {W{1'b0}};
      work_q       <= {W{1'b0}};
      cnt_q        <= {CW{1'b0}};
      carry_q      <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_sum_q    <= {W{1'b0}};
      rsp_c_out_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      carry_q      <= carry_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_c_out_q  <= rsp_c_out_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_c_out = rsp_c_out_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fa_nibble_seq_sched.sv
// Directed bench for fa_nibble_seq_sched: a 4-nibble instance and a 1-nibble instance.
module tb_fa_nibble_seq_sched;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_c_out, rsp_id, busy;
  logic [15:0] rsp_sum;

  logic        n_req0_valid, n_req0_ready, n_req1_valid, n_req1_ready;
  logic [3:0]  n_req0_a, n_req0_b, n_req1_a, n_req1_b;
  logic        n_rsp_valid, n_rsp_ready, n_rsp_c_out, n_rsp_id, n_busy;
  logic [3:0]  n_rsp_sum;

  int compared;
  int mismatched;
  int lat;
  int gr;

  fa_nibble_seq_sched #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_c_out(rsp_c_out), .rsp_id(rsp_id), .busy(busy)
  );

  fa_nibble_seq_sched #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(n_req0_valid), .req0_ready(n_req0_ready), .req0_a(n_req0_a), .req0_b(n_req0_b),
    .req1_valid(n_req1_valid), .req1_ready(n_req1_ready), .req1_a(n_req1_a), .req1_b(n_req1_b),
    .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready), .rsp_sum(n_rsp_sum),
    .rsp_c_out(n_rsp_c_out), .rsp_id(n_rsp_id), .busy(n_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance from cycle 0 until rsp_valid, returning the cycle index reached.
  task automatic wait_rsp(output int n);
    n = 1;
    cyc();
    while (!rsp_valid && n < 20) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 16'h0000; req0_b = 16'h0000; req1_a = 16'h0000; req1_b = 16'h0000;
    n_req0_valid = 1'b0; n_req1_valid = 1'b0; n_rsp_ready = 1'b0;
    n_req0_a = 4'h0; n_req0_b = 4'h0; n_req1_a = 4'h0; n_req1_b = 4'h0;
    cyc(); cyc();
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_sum",   32'(rsp_sum),   32'h0);
    chk("rst_cout",  32'(rsp_c_out), 32'h0);
    chk("rst_id",    32'(rsp_id),    32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    rst = 1'b0;
    cyc();

    // Test 1: basic req0 add
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321; rsp_ready = 1'b1;
    #1;
    chk("t1_r0rdy", 32'(req0_ready), 32'h1);
    chk("t1_r1rdy", 32'(req1_ready), 32'h0);
    cyc();
    req0_valid = 1'b0;
    chk("t1_busy", 32'(busy), 32'h1);
    lat = 1;
    while (!rsp_valid && lat < 20) begin cyc(); lat++; end
    chk("t1_lat",  32'(lat),       32'd5);
    chk("t1_sum",  32'(rsp_sum),   32'h5555);
    chk("t1_cout", 32'(rsp_c_out), 32'h0);
    chk("t1_id",   32'(rsp_id),    32'h0);
    cyc();
    chk("t1_idle_valid", 32'(rsp_valid), 32'h0);
    chk("t1_idle_busy",  32'(busy),      32'h0);

    // Test 2: full carry ripple from req1
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001;
    #1;
    chk("t2_r1rdy", 32'(req1_ready), 32'h1);
    cyc();
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin cyc(); lat++; end
    chk("t2_lat",  32'(lat),       32'd5);
    chk("t2_sum",  32'(rsp_sum),   32'h0000);
    chk("t2_cout", 32'(rsp_c_out), 32'h1);
    chk("t2_id",   32'(rsp_id),    32'h1);
    cyc();

    // Test 3: both valid continuously, grants alternate starting with req0
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_a = 16'h0010; req1_b = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      #1;
      gr = 0;
      while (!(req0_ready || req1_ready) && gr < 20) begin cyc(); gr++; end
      chk("t3_one_ready", 32'(req0_ready ^ req1_ready), 32'h1);
      chk("t3_grant",     32'(req1_ready), 32'(i % 2));
      wait_rsp(lat);
      chk("t3_lat", 32'(lat), 32'd5);
      chk("t3_id",  32'(rsp_id), 32'(i % 2));
      chk("t3_sum", 32'(rsp_sum), (i % 2 == 1) ? 32'h0020 : 32'h0002);
      cyc();
    end

    // Test 4: back-pressure in DONE
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h0F0F; req0_b = 16'h0101; rsp_ready = 1'b0;
    #1;
    chk("t4_r0rdy", 32'(req0_ready), 32'h1);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h7000; req1_b = 16'h9001;
    chk("t4_run_r1rdy", 32'(req1_ready), 32'h0);
    lat = 1;
    while (!rsp_valid && lat < 20) begin cyc(); lat++; end
    chk("t4_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", 32'(rsp_valid), 32'h1);
      chk("t4_hold_sum",   32'(rsp_sum),   32'h1010);
      chk("t4_hold_id",    32'(rsp_id),    32'h0);
      chk("t4_hold_rdy",   32'({req0_ready, req1_ready}), 32'h0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_hs_valid", 32'(rsp_valid),  32'h1);
    chk("t4_hs_r1rdy", 32'(req1_ready), 32'h0);
    cyc();
    chk("t4_idle_valid", 32'(rsp_valid),  32'h0);
    chk("t4_idle_r1rdy", 32'(req1_ready), 32'h1);
    cyc();
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin cyc(); lat++; end
    chk("t4b_lat",  32'(lat),       32'd5);
    chk("t4b_sum",  32'(rsp_sum),   32'h0001);
    chk("t4b_cout", 32'(rsp_c_out), 32'h1);
    chk("t4b_id",   32'(rsp_id),    32'h1);
    cyc();

    // Test 5: reset during the second RUN cycle
    req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222;
    #1;
    chk("t5_r0rdy", 32'(req0_ready), 32'h1);
    cyc();
    req0_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_valid", 32'(rsp_valid), 32'h0);
    chk("t5_busy",  32'(busy),      32'h0);
    chk("t5_sum",   32'(rsp_sum),   32'h0);
    chk("t5_cout",  32'(rsp_c_out), 32'h0);
    chk("t5_id",    32'(rsp_id),    32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t5_no_rsp", 32'(rsp_valid), 32'h0);
    end
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_a = 16'h5555; req1_b = 16'h5555;
    #1;
    chk("t5_tie_r0", 32'(req0_ready), 32'h1);
    chk("t5_tie_r1", 32'(req1_ready), 32'h0);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin cyc(); lat++; end
    chk("t5_lat",   32'(lat),       32'd5);
    chk("t5_sum2",  32'(rsp_sum),   32'h0100);
    chk("t5_cout2", 32'(rsp_c_out), 32'h0);
    chk("t5_id2",   32'(rsp_id),    32'h0);
    cyc();

    // Test 6: single-nibble instance
    n_req0_valid = 1'b1; n_req0_a = 4'hF; n_req0_b = 4'h1; n_rsp_ready = 1'b1;
    #1;
    chk("t6_r0rdy", 32'(n_req0_ready), 32'h1);
    cyc();
    n_req0_valid = 1'b0;
    lat = 1;
    while (!n_rsp_valid && lat < 20) begin cyc(); lat++; end
    chk("t6_lat",  32'(lat),         32'd2);
    chk("t6_sum",  32'(n_rsp_sum),   32'h0);
    chk("t6_cout", 32'(n_rsp_c_out), 32'h1);
    chk("t6_id",   32'(n_rsp_id),    32'h0);
    cyc();
    chk("t6_idle", 32'(n_rsp_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
